// File: rtl/lcd_frame_streamer_pkg.sv
// Shared LCD constants: command codes, pattern modes and streamer states.
package lcd_frame_streamer_pkg;

   localparam int unsigned DA_W = 2;

   // Command types understood by the LCD instruction engine.
   typedef enum logic [DA_W-1:0] {
      WRITE_DATA               = 2'd2,
      WRITE_DISPLAY_START_LINE = 2'd3
   } data_action_e;

   typedef enum logic [1:0] {
      MODE_FILL     = 2'd0,
      MODE_TRIANGLE = 2'd1,
      MODE_CHECKER  = 2'd2,
      MODE_VBARS    = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAW,
      ST_SCROLL_WAIT,
      ST_SCROLL_STEP
   } state_e;

endpackage

// File: rtl/lcd_frame_streamer_if.sv
// Control / instruction-engine bundle of the frame streamer.
// master: control logic and instruction engine side; slave: the streamer.
interface lcd_frame_streamer_if #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned PAGE_COUNT = 8,
   parameter int unsigned COL_COUNT  = 64,
   parameter int unsigned ROW_COUNT  = 64,
   parameter int unsigned DELAY_W    = 12
) ();
   localparam int unsigned XW  = (PAGE_COUNT > 1) ? $clog2(PAGE_COUNT) : 1;
   localparam int unsigned YW  = (COL_COUNT > 1) ? $clog2(COL_COUNT) : 1;
   localparam int unsigned SLW = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1;

   logic                                   start;
   logic                                   stop;
   logic [1:0]                             mode;
   logic [DATA_W-1:0]                      fill_value;
   logic                                   scroll_en;
   logic                                   scroll_dir;
   logic [DELAY_W-1:0]                     scroll_delay;
   logic                                   instr_busy;
   logic [DATA_W-1:0]                      data;
   logic [SLW-1:0]                         start_line;
   logic [YW-1:0]                          addr_y;
   logic [XW-1:0]                          addr_x;
   logic [lcd_frame_streamer_pkg::DA_W-1:0] data_action;
   logic                                   data_busy;
   logic                                   frame_done;
   logic                                   active;

   modport master (
      output start, stop, mode, fill_value, scroll_en, scroll_dir, scroll_delay, instr_busy,
      input  data, start_line, addr_y, addr_x, data_action, data_busy, frame_done, active
   );

   modport slave (
      input  start, stop, mode, fill_value, scroll_en, scroll_dir, scroll_delay, instr_busy,
      output data, start_line, addr_y, addr_x, data_action, data_busy, frame_done, active
   );

endinterface

// File: rtl/lcd_frame_streamer_pattern_gen.sv
// Combinational pixel-column pattern: (mode, fill, page x, column y) -> data.
module lcd_pattern_gen
   import lcd_frame_streamer_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned XW     = 3,
   parameter int unsigned YW     = 6
) (
   input  mode_e             mode_i,
   input  logic [DATA_W-1:0] fill_i,
   input  logic [XW-1:0]     x_i,
   input  logic [YW-1:0]     y_i,
   output logic [DATA_W-1:0] data_o
);
   localparam int unsigned       BB   = $clog2(DATA_W);
   localparam logic [DATA_W-1:0] ONES = '1;

   // Pattern select; triangle ramps down every DATA_W columns.
   always_comb begin
      data_o = '0;
      case (mode_i)
         MODE_FILL:     data_o = fill_i;
         MODE_TRIANGLE: data_o = ONES >> (32'(y_i) % DATA_W);
         MODE_CHECKER:  data_o = (((32'(y_i) / DATA_W + 32'(x_i)) % 2) != 0) ? ONES : '0;
         MODE_VBARS:    data_o = (((32'(y_i) >> BB) % 2) != 0) ? ONES : '0;
         default:       data_o = '0;
      endcase
   end

endmodule

// File: rtl/lcd_frame_streamer.sv
// Streams one frame of pattern data to the LCD instruction engine, then
// optionally scrolls the start line. A handshake slot is consumed only when a
// command is actually issued.
module lcd_frame_streamer
   import lcd_frame_streamer_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned PAGE_COUNT = 8,
   parameter int unsigned COL_COUNT  = 64,
   parameter int unsigned ROW_COUNT  = 64,
   parameter int unsigned DELAY_W    = 12
) (
   input logic                 clk_ctrl,
   input logic                 reset_n,
   lcd_frame_streamer_if.slave bus
);
   localparam int unsigned XW  = (PAGE_COUNT > 1) ? $clog2(PAGE_COUNT) : 1;
   localparam int unsigned YW  = (COL_COUNT > 1) ? $clog2(COL_COUNT) : 1;
   localparam int unsigned SLW = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1;

   localparam logic [XW-1:0]  X_LAST  = XW'(PAGE_COUNT - 1);
   localparam logic [YW-1:0]  Y_LAST  = YW'(COL_COUNT - 1);
   localparam logic [SLW-1:0] SL_LAST = SLW'(ROW_COUNT - 1);

   state_e             state_q, state_d;
   mode_e              mode_q, mode_d;
   logic [DATA_W-1:0]  fill_q, fill_d;
   logic               scroll_en_q, scroll_en_d;
   logic               scroll_dir_q, scroll_dir_d;
   logic [DELAY_W-1:0] delay_q, delay_d;
   logic [DELAY_W-1:0] cnt_q, cnt_d;
   logic [XW-1:0]      px_x_q, px_x_d;
   logic [YW-1:0]      px_y_q, px_y_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [SLW-1:0]     start_line_q, start_line_d;
   logic [XW-1:0]      addr_x_q, addr_x_d;
   logic [YW-1:0]      addr_y_q, addr_y_d;
   data_action_e       action_q, action_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [DATA_W-1:0]  pat_data;
   logic               slot;
   logic               relatch;

   lcd_pattern_gen #(
      .DATA_W (DATA_W),
      .XW     (XW),
      .YW     (YW)
   ) u_pattern (
      .mode_i (mode_q),
      .fill_i (fill_q),
      .x_i    (px_x_q),
      .y_i    (px_y_q),
      .data_o (pat_data)
   );

   // Next-state: stop overrides everything, start relatches outside DRAW.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      fill_d       = fill_q;
      scroll_en_d  = scroll_en_q;
      scroll_dir_d = scroll_dir_q;
      delay_d      = delay_q;
      cnt_d        = cnt_q;
      px_x_d       = px_x_q;
      px_y_d       = px_y_q;
      data_d       = data_q;
      start_line_d = start_line_q;
      addr_x_d     = addr_x_q;
      addr_y_d     = addr_y_q;
      action_d     = action_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      relatch      = 1'b0;
      slot         = !bus.instr_busy && busy_q;

      if (bus.instr_busy) busy_d = 1'b1;

      if (bus.stop) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) relatch = 1'b1;
            end
            ST_DRAW: begin
               if (slot) begin
                  data_d   = pat_data;
                  addr_x_d = px_x_q;
                  addr_y_d = px_y_q;
                  action_d = WRITE_DATA;
                  busy_d   = 1'b0;
                  if (px_y_q == Y_LAST) begin
                     px_y_d = '0;
                     if (px_x_q == X_LAST) begin
                        px_x_d  = '0;
                        done_d  = 1'b1;
                        state_d = scroll_en_q ? ST_SCROLL_WAIT : ST_IDLE;
                     end else begin
                        px_x_d = px_x_q + XW'(1);
                     end
                  end else begin
                     px_y_d = px_y_q + YW'(1);
                  end
               end
            end
            ST_SCROLL_WAIT: begin
               if (bus.start) begin
                  relatch = 1'b1;
               end else if (cnt_q == delay_q) begin
                  cnt_d   = '0;
                  state_d = ST_SCROLL_STEP;
               end else begin
                  cnt_d = cnt_q + DELAY_W'(1);
               end
            end
            ST_SCROLL_STEP: begin
               if (bus.start) begin
                  relatch = 1'b1;
               end else if (slot) begin
                  action_d = WRITE_DISPLAY_START_LINE;
                  busy_d   = 1'b0;
                  state_d  = ST_SCROLL_WAIT;
                  if (!scroll_dir_q)
                     start_line_d = (start_line_q == SL_LAST) ? '0 : start_line_q + SLW'(1);
                  else
                     start_line_d = (start_line_q == '0) ? SL_LAST : start_line_q - SLW'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (relatch) begin
         mode_d       = mode_e'(bus.mode);
         fill_d       = bus.fill_value;
         scroll_en_d  = bus.scroll_en;
         scroll_dir_d = bus.scroll_dir;
         delay_d      = bus.scroll_delay;
         px_x_d       = '0;
         px_y_d       = '0;
         cnt_d        = '0;
         state_d      = ST_DRAW;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_ctrl or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         mode_q       <= MODE_FILL;
         fill_q       <= '0;
         scroll_en_q  <= 1'b0;
         scroll_dir_q <= 1'b0;
         delay_q      <= '0;
         cnt_q        <= '0;
         px_x_q       <= '0;
         px_y_q       <= '0;
         data_q       <= '0;
         start_line_q <= '0;
         addr_x_q     <= '0;
         addr_y_q     <= '0;
         action_q     <= WRITE_DATA;
         busy_q       <= 1'b1;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         fill_q       <= fill_d;
         scroll_en_q  <= scroll_en_d;
         scroll_dir_q <= scroll_dir_d;
         delay_q      <= delay_d;
         cnt_q        <= cnt_d;
         px_x_q       <= px_x_d;
         px_y_q       <= px_y_d;
         data_q       <= data_d;
         start_line_q <= start_line_d;
         addr_x_q     <= addr_x_d;
         addr_y_q     <= addr_y_d;
         action_q     <= action_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign bus.data        = data_q;
   assign bus.start_line  = start_line_q;
   assign bus.addr_x      = addr_x_q;
   assign bus.addr_y      = addr_y_q;
   assign bus.data_action = action_q;
   assign bus.data_busy   = busy_q;
   assign bus.frame_done  = done_q;
   assign bus.active      = (state_q != ST_IDLE);

endmodule
